// File: rtl/mem_pkg.sv
// Shared packet-buffer definitions: block index width and free-list state encoding.
package mem_pkg;
  localparam int ADDR_W = 4;

  typedef enum logic {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } fl_state_e;
endpackage

// File: rtl/fl_fifo.sv
// Circular store of free block indices with an init write port, pointers and a registered count.
module fl_fifo
  import mem_pkg::*;
#(
  parameter int NUM_BLOCKS = 1 << ADDR_W,
  localparam int PTR_W = $clog2(NUM_BLOCKS),
  localparam int CNT_W = $clog2(NUM_BLOCKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init_we,
  input  logic [PTR_W-1:0]  i_init_ptr,
  input  logic              i_init_last,
  input  logic              i_pop,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_idx,
  output logic [ADDR_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty
);
  logic [ADDR_W-1:0] r_mem [NUM_BLOCKS];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_empty;

  // Pointers wrap explicitly so NUM_BLOCKS need not be a power of two.
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_BLOCKS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !i_pop)      w_count_nxt = r_count + 1'b1;
    else if (i_pop && !i_push) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_init_we)   r_mem[i_init_ptr] <= ADDR_W'(i_init_ptr);
    else if (i_push) r_mem[r_wr_ptr]   <= i_push_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
    end else if (i_init_we) begin
      if (i_init_last) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= CNT_W'(NUM_BLOCKS);
        r_empty  <= 1'b0;
      end
    end else begin
      if (i_pop)  r_rd_ptr <= nxt(r_rd_ptr);
      if (i_push) r_wr_ptr <= nxt(r_wr_ptr);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = r_empty;
endmodule

// File: rtl/mem_free_list.sv
// Packet-buffer free-list manager: init sweep, zero-latency grants, and bitmap-checked frees.
module mem_free_list
  import mem_pkg::*;
#(
  parameter int NUM_BLOCKS = 1 << ADDR_W,
  localparam int PTR_W = $clog2(NUM_BLOCKS),
  localparam int CNT_W = $clog2(NUM_BLOCKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fl_alloc_req_i,
  output logic              fl_alloc_gnt_o,
  output logic [ADDR_W-1:0] fl_alloc_block_idx_o,
  input  logic              fl_free_req_i,
  input  logic [ADDR_W-1:0] fl_free_block_idx_i,
  output logic              fl_init_done_o,
  output logic [CNT_W-1:0]  fl_free_count_o,
  output logic              fl_empty_o,
  output logic              fl_err_o
);
  fl_state_e             r_state;
  logic [PTR_W-1:0]      r_init_ptr;
  logic [NUM_BLOCKS-1:0] r_bmp;
  logic                  r_err;

  logic              w_run, w_init_we, w_init_last, w_gnt, w_empty;
  logic              w_in_range, w_free_ok;
  logic [ADDR_W-1:0] w_head;
  logic [PTR_W-1:0]  w_free_slot;
  logic [CNT_W-1:0]  w_count;

  assign w_run       = (r_state == FL_RUN);
  assign w_init_we   = (r_state == FL_INIT);
  assign w_init_last = w_init_we && (r_init_ptr == PTR_W'(NUM_BLOCKS - 1));
  assign w_gnt       = w_run && fl_alloc_req_i && !w_empty;

  assign w_in_range  = ({1'b0, fl_free_block_idx_i} < (ADDR_W + 1)'(NUM_BLOCKS));
  assign w_free_slot = w_in_range ? fl_free_block_idx_i[PTR_W-1:0] : '0;
  // A block cannot be both handed out and returned in one cycle; that pairing is a protocol error.
  assign w_free_ok   = fl_free_req_i && w_run && w_in_range && r_bmp[w_free_slot] &&
                       !(w_gnt && (w_head == fl_free_block_idx_i));

  fl_fifo #(.NUM_BLOCKS(NUM_BLOCKS)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_init_we   (w_init_we),
    .i_init_ptr  (r_init_ptr),
    .i_init_last (w_init_last),
    .i_pop       (w_gnt),
    .i_push      (w_free_ok),
    .i_push_idx  (fl_free_block_idx_i),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FL_INIT;
      r_init_ptr <= '0;
      r_bmp      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        FL_INIT: begin
          if (w_init_last) begin
            r_state    <= FL_RUN;
            r_init_ptr <= '0;
          end else begin
            r_init_ptr <= r_init_ptr + 1'b1;
          end
        end
        default: r_state <= FL_RUN;
      endcase
      if (w_gnt)     r_bmp[w_head[PTR_W-1:0]] <= 1'b1;
      if (w_free_ok) r_bmp[w_free_slot]       <= 1'b0;
      if (fl_free_req_i && !w_free_ok) r_err <= 1'b1;
    end
  end

  assign fl_alloc_gnt_o       = w_gnt;
  assign fl_alloc_block_idx_o = w_gnt ? w_head : '0;
  assign fl_init_done_o       = w_run;
  assign fl_free_count_o      = w_count;
  assign fl_empty_o           = w_empty;
  assign fl_err_o             = r_err;
endmodule

// File: tb/tb_mem_free_list.sv
// Directed bench for mem_free_list with NUM_BLOCKS = 8.
module tb_mem_free_list;
  import mem_pkg::*;
  localparam int NB = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req, gnt, frq, done, empty, err;
  logic [ADDR_W-1:0] gidx, fidx;
  logic [3:0]        cnt;
  int                total = 0, fails = 0;

  mem_free_list #(.NUM_BLOCKS(NB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .fl_alloc_req_i       (req),
    .fl_alloc_gnt_o       (gnt),
    .fl_alloc_block_idx_o (gidx),
    .fl_free_req_i        (frq),
    .fl_free_block_idx_i  (fidx),
    .fl_init_done_o       (done),
    .fl_free_count_o      (cnt),
    .fl_empty_o           (empty),
    .fl_err_o             (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_idx"}, 32'(gidx), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cnt"}, 32'(cnt), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    logic [ADDR_W-1:0] seq4 [6];
    logic [ADDR_W-1:0] frees4 [6];
    seq4   = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};
    frees4 = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    rst = 1'b1; req = 1'b0; frq = 1'b0; fidx = '0;
    repeat (2) tick();
    chk_reset_vals("rst");

    // 1: init sweep with a request held from cycle 0
    req = 1'b1; rst = 1'b0;
    repeat (7) tick();
    chk("init_c7_done", 32'(done), 0);
    chk("init_c7_gnt", 32'(gnt), 0);
    tick();
    chk("init_c8_done", 32'(done), 1);
    chk("init_c8_cnt", 32'(cnt), NB);
    chk("init_c8_empty", 32'(empty), 0);

    // 2: drain all eight blocks in order
    for (int i = 0; i < NB; i++) begin
      chk("drain_gnt", 32'(gnt), 1);
      chk("drain_idx", 32'(gidx), 32'(i));
      tick();
    end
    chk("drain_cnt", 32'(cnt), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_gnt_lo", 32'(gnt), 0);
    tick();
    chk("drain_gnt_lo2", 32'(gnt), 0);

    // 3: free 5 while empty, granted next cycle
    frq = 1'b1; fidx = 4'd5;
    chk("empty_free_gnt", 32'(gnt), 0);
    tick();
    frq = 1'b0;
    chk("refill_cnt", 32'(cnt), 1);
    chk("refill_gnt", 32'(gnt), 1);
    chk("refill_idx", 32'(gidx), 5);
    tick();
    chk("refill_cnt0", 32'(cnt), 0);
    chk("refill_gnt_lo", 32'(gnt), 0);

    // 4: queue 2..7, then simultaneous grant of 2 and free of 0
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      frq = 1'b1; fidx = frees4[i];
      tick();
    end
    frq = 1'b0;
    chk("queue_cnt", 32'(cnt), 6);
    req = 1'b1; frq = 1'b1; fidx = 4'd0;
    #1;
    chk("both_idx", 32'(gidx), 2);
    tick();
    frq = 1'b0;
    chk("both_cnt", 32'(cnt), 6);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fifo_gnt", 32'(gnt), 1);
      chk("fifo_idx", 32'(gidx), 32'(seq4[i]));
      tick();
    end
    chk("fifo_empty", 32'(empty), 1);

    // 5: legal free, out-of-range free, double free
    req = 1'b0; frq = 1'b1; fidx = 4'd4;
    tick();
    chk("free4_cnt", 32'(cnt), 1);
    chk("free4_err", 32'(err), 0);
    fidx = 4'd9;
    tick();
    chk("oor_err", 32'(err), 1);
    chk("oor_cnt", 32'(cnt), 1);
    fidx = 4'd4;
    tick();
    chk("dbl_cnt", 32'(cnt), 1);
    chk("dbl_err", 32'(err), 1);
    frq = 1'b0; req = 1'b1;
    #1;
    chk("after_err_idx", 32'(gidx), 4);
    tick();
    chk("after_err_empty", 32'(empty), 1);

    // 6: reset clears error; free during INIT is rejected
    rst = 1'b1;
    #1;
    chk_reset_vals("rst2");
    tick();
    rst = 1'b0;
    repeat (2) tick();
    frq = 1'b1; fidx = 4'd1;
    tick();
    frq = 1'b0;
    chk("init_free_err", 32'(err), 1);
    chk("init_free_cnt", 32'(cnt), 0);
    repeat (5) tick();
    chk("init2_cnt", 32'(cnt), NB);
    for (int i = 0; i < 3; i++) begin
      chk("pre_rst_idx", 32'(gidx), 32'(i));
      tick();
    end
    chk("pre_rst_cnt", 32'(cnt), 5);

    // reset mid-operation with outstanding allocations
    rst = 1'b1;
    #1;
    chk_reset_vals("rst3");
    tick();
    rst = 1'b0;
    repeat (7) tick();
    chk("sweep3_c7_gnt", 32'(gnt), 0);
    tick();
    chk("sweep3_gnt", 32'(gnt), 1);
    chk("sweep3_idx", 32'(gidx), 0);
    chk("sweep3_cnt", 32'(cnt), NB);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_free_list.md
# mem_free_list

Free-list manager for the shared packet buffer. It serves single-block allocation requests from the round-robin allocation arbiter in front of the memory write controllers, and it accepts released block indices from the read side. After reset it runs an initialisation sweep that loads every block index. It then keeps a FIFO of free indices plus an allocation bitmap, which it uses to reject double or out-of-range frees.

## Interface
Parameters:
- NUM_BLOCKS, default 1<<ADDR_W: number of buffer blocks. Must be ≤ 2**ADDR_W and ≥ 2.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: asynchronous, active-high reset.
- fl_alloc_req_i, input, 1: allocation request; level, held by the requester until granted.
- fl_alloc_gnt_o, output, 1: one-cycle grant; the index is valid in the same cycle.
- fl_alloc_block_idx_o, output, ADDR_W: granted block index; 0 when the grant is low.
- fl_free_req_i, input, 1: release strobe, one block per cycle.
- fl_free_block_idx_i, input, ADDR_W: index being released.
- fl_init_done_o, output, 1: high once the init sweep has completed.
- fl_free_count_o, output, $clog2(NUM_BLOCKS+1): number of free blocks.
- fl_empty_o, output, 1: fl_free_count_o == 0.
- fl_err_o, output, 1: sticky; set by an illegal free. Cleared only by rst.

## Operation
- FIFO storage:
  - mem[NUM_BLOCKS] of ADDR_W bits.
  - rd_ptr and wr_ptr each $clog2(NUM_BLOCKS) bits, wrapping at NUM_BLOCKS−1 → 0 (NUM_BLOCKS need not be a power of two).
  - count register.
- alloc_bmp[NUM_BLOCKS]: bit i set means block i is allocated.
- State machine:
  - INIT: init_ptr counts 0..NUM_BLOCKS−1 and writes mem[init_ptr] = init_ptr, one entry per cycle.
    - On the last write: wr_ptr = 0, rd_ptr = 0, count = NUM_BLOCKS, go to RUN.
    - No grants are given in INIT.
    - Frees during INIT are illegal: they are dropped and set fl_err_o.
  - RUN: normal operation. No exit except rst.
- Allocation:
  - gnt = RUN & fl_alloc_req_i & (count != 0).
  - fl_alloc_block_idx_o = mem[rd_ptr], read combinationally.
  - On gnt: rd_ptr advances, count−1, alloc_bmp[idx] is set.
- Free legality: a free is legal when all of the following hold:
  - the block is in RUN,
  - idx < NUM_BLOCKS,
  - alloc_bmp[idx] = 1,
  - the index is not the one being granted in the same cycle.
- Free handling:
  - Legal free: mem[wr_ptr] = idx, wr_ptr advances, count+1, alloc_bmp[idx] is cleared.
  - Illegal free: no state change except fl_err_o ← 1.
- Simultaneous alloc grant and legal free: count is unchanged and both pointers advance.
- Empty: requests are held off with gnt = 0. There is no free-to-alloc bypass, so a block freed while the list is empty is grantable from the next cycle.
- Count never exceeds NUM_BLOCKS. The bitmap guarantees this, so no separate overflow check is needed.

## Timing
- Reset values:
  - fl_alloc_gnt_o = 0, fl_alloc_block_idx_o = 0.
  - fl_init_done_o = 0, fl_free_count_o = 0, fl_empty_o = 1, fl_err_o = 0.
  - state = INIT; init_ptr, rd_ptr and wr_ptr = 0; alloc_bmp = 0.
- After rst deasserts, INIT lasts exactly NUM_BLOCKS cycles. fl_init_done_o and count = NUM_BLOCKS are visible on cycle NUM_BLOCKS.
- Grant latency is 0 cycles: the grant is combinational from req in RUN. Max throughput is one alloc plus one free per cycle.
- A freed block is allocatable one cycle after its free strobe, and is returned in FIFO order behind the blocks already queued.
- fl_free_count_o and fl_empty_o are registered and reflect the previous edge.
- rst asserted mid-operation returns every register to its reset value immediately, and the INIT sweep restarts. Outstanding allocations are forgotten.

## Structure
- In mem_pkg: ADDR_W (already shared) and a new fl_state_e enum {FL_INIT, FL_RUN}.
- One sub-module: fl_fifo, holding the circular index storage, pointers, count and init write port. mem_free_list holds the FSM, the bitmap, the legality check and the error flag.

## Test plan
Use NUM_BLOCKS = 8 for all scenarios.
1. Reset, then idle: fl_init_done_o rises on cycle 8 and fl_free_count_o = 8. A req held from cycle 0 gets its first gnt on cycle 8, with idx 0.
2. req held for 9 cycles after init: grants with idx 0..7 on consecutive cycles, then fl_empty_o = 1 and gnt stays low.
3. From empty, free idx 5: the next cycle gives gnt with idx 5 and count goes 1 → 0.
4. In one cycle, alloc (granting idx 2) and free idx 0, which was allocated earlier: count is unchanged. Subsequent grants return idx 3..7 then idx 0.
5. Free idx 4 twice: the second free sets fl_err_o = 1 and count rises only once. A free with idx 9 (≥ NUM_BLOCKS, with ADDR_W ≥ 4) sets fl_err_o and is dropped.
6. Assert rst after 3 grants: all outputs return to their reset values, and the sweep restarts with the first grant on cycle 8 returning idx 0.
